// File: rtl/audio_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : audio_controller (with helper audio_fifo)                      |
// | Purpose  : Codec-slave audio interface. Deserialises left-justified ADC   |
// |            data into per-channel input FIFOs and serialises output FIFO   |
// |            contents onto the DAC line. Generates the codec master clock.  |
// | Ports    : CLOCK_50/reset            - system clock, async active-low rst |
// |            clear_audio_*_memory      - flush input / output FIFO pair     |
// |            read_audio_in             - pop one input L/R pair             |
// |            write_audio_out, *_out    - push one output L/R pair           |
// |            audio_in_available        - both input FIFOs hold a sample     |
// |            audio_out_allowed         - both output FIFOs have room        |
// |            AUD_*                     - codec pins (BCLK/LRCKs are inputs) |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+

// Show-ahead FIFO with an extra pointer bit to tell full from empty.
module audio_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wptr_q[AW-1:0]] <= data_i;
   end
endmodule

module audio_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 128
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  clear_audio_in_memory,
   input  logic                  read_audio_in,
   input  logic                  clear_audio_out_memory,
   input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
   input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
   input  logic                  write_audio_out,
   input  logic                  AUD_ADCDAT,
   inout  wire                   AUD_BCLK,
   inout  wire                   AUD_ADCLRCK,
   inout  wire                   AUD_DACLRCK,
   output logic                  audio_in_available,
   output logic [DATA_WIDTH-1:0] left_channel_audio_in,
   output logic [DATA_WIDTH-1:0] right_channel_audio_in,
   output logic                  audio_out_allowed,
   output logic                  AUD_XCK,
   output logic                  AUD_DACDAT
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] MSB_IDX  = IW'(DATA_WIDTH - 1);

   // The codec masters all serial clocks; these pins are only ever observed.
   assign AUD_BCLK    = 1'bz;
   assign AUD_ADCLRCK = 1'bz;
   assign AUD_DACLRCK = 1'bz;

   // Sync bit order: [3]=ADCDAT, [2]=DACLRCK, [1]=ADCLRCK, [0]=BCLK.
   // ADCDAT rides the same chain so it stays aligned with the delayed BCLK.
   logic [3:0] sync1_q, sync2_q;
   logic [2:0] prev_q;
   logic [1:0] rdy_q;
   logic       rdy;
   logic [2:0] rise, fall;
   logic       xck_div_q, xck_q;

   logic [DATA_WIDTH-1:0] adc_sr_q, adc_sr_d, dac_sr_q, dac_sr_d;
   logic [CW-1:0]         adc_cnt_q, adc_cnt_d, dac_cnt_q, dac_cnt_d;
   logic                  adc_armed_q, adc_armed_d, dacdat_q, dacdat_d;
   logic                  push_il, push_ir, pop_ol, pop_or, in_pop, out_push;

   logic [DATA_WIDTH-1:0] il_head, ir_head, ol_head, or_head;
   logic il_empty, ir_empty, ol_empty, or_empty, ol_full, or_full;
   logic il_full_unused, ir_full_unused;

   // The chain powers up at zero; edges seen before it has filled are artefacts.
   assign rdy  = &rdy_q;
   assign rise = sync2_q[2:0] & ~prev_q & {3{rdy}};
   assign fall = ~sync2_q[2:0] & prev_q & {3{rdy}};

   assign audio_in_available     = !il_empty && !ir_empty;
   assign audio_out_allowed      = !ol_full && !or_full;
   assign in_pop                 = read_audio_in && audio_in_available;
   assign out_push               = write_audio_out && audio_out_allowed;
   assign left_channel_audio_in  = il_empty ? '0 : il_head;
   assign right_channel_audio_in = ir_empty ? '0 : ir_head;
   assign AUD_XCK                = xck_q;
   assign AUD_DACDAT             = dacdat_q;

   // ADC deserialiser. Bits land MSB-down at their final position, so a short
   // word is left-justified with zero LSBs. Nothing is pushed until the first
   // LRCK edge after reset, which discards any partial word.
   always_comb begin
      adc_sr_d    = adc_sr_q;
      adc_cnt_d   = adc_cnt_q;
      adc_armed_d = adc_armed_q;
      push_il     = 1'b0;
      push_ir     = 1'b0;
      if (rise[1] || fall[1]) begin
         push_il     = adc_armed_q && fall[1];
         push_ir     = adc_armed_q && rise[1];
         adc_armed_d = 1'b1;
         adc_sr_d    = '0;
         adc_cnt_d   = '0;
      end
      if (rise[0] && (adc_cnt_d < CNT_FULL)) begin
         adc_sr_d[MSB_IDX - adc_cnt_d[IW-1:0]] = sync2_q[3];
         adc_cnt_d = adc_cnt_d + CNT_ONE;
      end
   end

   // DAC serialiser. The codec moves LRCK on a BCLK falling edge, so a load
   // and the first shift usually happen together and the MSB goes out at once.
   // A left load requires the whole pair to be present; the right half only
   // needs its own FIFO because the matching left entry was just consumed.
   always_comb begin
      dac_sr_d  = dac_sr_q;
      dac_cnt_d = dac_cnt_q;
      dacdat_d  = dacdat_q;
      pop_ol    = 1'b0;
      pop_or    = 1'b0;
      if (rise[2]) begin
         pop_ol    = !ol_empty && !or_empty;
         dac_sr_d  = pop_ol ? ol_head : '0;
         dac_cnt_d = '0;
      end else if (fall[2]) begin
         pop_or    = !or_empty;
         dac_sr_d  = pop_or ? or_head : '0;
         dac_cnt_d = '0;
      end
      if (fall[0]) begin
         if (dac_cnt_d < CNT_FULL) begin
            dacdat_d  = dac_sr_d[DATA_WIDTH-1];
            dac_sr_d  = {dac_sr_d[DATA_WIDTH-2:0], 1'b0};
            dac_cnt_d = dac_cnt_d + CNT_ONE;
         end else begin
            dacdat_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         rdy_q       <= '0;
         xck_div_q   <= 1'b0;
         xck_q       <= 1'b0;
         adc_sr_q    <= '0;
         adc_cnt_q   <= '0;
         adc_armed_q <= 1'b0;
         dac_sr_q    <= '0;
         dac_cnt_q   <= '0;
         dacdat_q    <= 1'b0;
      end else begin
         sync1_q     <= {AUD_ADCDAT, AUD_DACLRCK, AUD_ADCLRCK, AUD_BCLK};
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q[2:0];
         if (!rdy) rdy_q <= rdy_q + 2'd1;
         xck_div_q   <= ~xck_div_q;
         if (xck_div_q) xck_q <= ~xck_q;
         adc_sr_q    <= adc_sr_d;
         adc_cnt_q   <= adc_cnt_d;
         adc_armed_q <= adc_armed_d;
         dac_sr_q    <= dac_sr_d;
         dac_cnt_q   <= dac_cnt_d;
         dacdat_q    <= dacdat_d;
      end
   end

   audio_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_left (
      .clk_i(CLOCK_50), .rst_ni(reset), .clr_i(clear_audio_in_memory),
      .push_i(push_il), .pop_i(in_pop), .data_i(adc_sr_q),
      .data_o(il_head), .empty_o(il_empty), .full_o(il_full_unused));

   audio_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_right (
      .clk_i(CLOCK_50), .rst_ni(reset), .clr_i(clear_audio_in_memory),
      .push_i(push_ir), .pop_i(in_pop), .data_i(adc_sr_q),
      .data_o(ir_head), .empty_o(ir_empty), .full_o(ir_full_unused));

   audio_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_left (
      .clk_i(CLOCK_50), .rst_ni(reset), .clr_i(clear_audio_out_memory),
      .push_i(out_push), .pop_i(pop_ol), .data_i(left_channel_audio_out),
      .data_o(ol_head), .empty_o(ol_empty), .full_o(ol_full));

   audio_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_right (
      .clk_i(CLOCK_50), .rst_ni(reset), .clr_i(clear_audio_out_memory),
      .push_i(out_push), .pop_i(pop_or), .data_i(right_channel_audio_out),
      .data_o(or_head), .empty_o(or_empty), .full_o(or_full));
endmodule
`default_nettype wire

// File: tb/tb_audio_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_audio_controller                                            |
// | Purpose  : Directed bench for audio_controller with a simple codec model   |
// |            (BCLK/LRCK master, left-justified MSB-first serial data).       |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_audio_controller;
   logic        clk = 1'b0;
   logic        rst_n, clr_in, rd_in, clr_out, wr_out, adcdat;
   logic [31:0] lo, ro, li, ri, dac;
   logic        bclk_drv, lrck_drv;
   logic        avail, allowed, xck, dacdat;
   wire         aud_bclk, aud_adclrck, aud_daclrck;
   int          total = 0;
   int          bad = 0;
   int          hp = 8;

   always #10 clk = ~clk;

   assign aud_bclk    = bclk_drv;
   assign aud_adclrck = lrck_drv;
   assign aud_daclrck = lrck_drv;

   audio_controller #(.DATA_WIDTH(32), .FIFO_DEPTH(128)) dut (
      .CLOCK_50(clk), .reset(rst_n),
      .clear_audio_in_memory(clr_in), .read_audio_in(rd_in),
      .clear_audio_out_memory(clr_out),
      .left_channel_audio_out(lo), .right_channel_audio_out(ro),
      .write_audio_out(wr_out), .AUD_ADCDAT(adcdat),
      .AUD_BCLK(aud_bclk), .AUD_ADCLRCK(aud_adclrck), .AUD_DACLRCK(aud_daclrck),
      .audio_in_available(avail), .left_channel_audio_in(li),
      .right_channel_audio_in(ri), .audio_out_allowed(allowed),
      .AUD_XCK(xck), .AUD_DACDAT(dacdat));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One LRCK half: the LRCK edge comes with the first BCLK fall. ADC bits
   // change on falls; the DAC line is sampled just before each rise.
   task automatic send_half(input logic lv, input logic [31:0] w, input int nbits,
                            output logic [31:0] d);
      d = '0;
      if (nbits == 0) begin
         @(negedge clk);
         bclk_drv = 1'b0;
         lrck_drv = lv;
         repeat (hp) @(negedge clk);
      end
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bclk_drv = 1'b0;
         if (i == 0) lrck_drv = lv;
         adcdat = w[nbits-1-i];
         repeat (hp) @(negedge clk);
         d = {d[30:0], dacdat};
         bclk_drv = 1'b1;
         repeat (hp - 1) @(negedge clk);
      end
   endtask

   task automatic wr_pair(input logic [31:0] l, input logic [31:0] r);
      @(negedge clk);
      lo = l; ro = r; wr_out = 1'b1;
      @(negedge clk);
      wr_out = 1'b0;
   endtask

   task automatic rd_pulse();
      @(negedge clk);
      rd_in = 1'b1;
      @(negedge clk);
      rd_in = 1'b0;
   endtask

   initial begin
      logic xck_seen;
      logic prevx;
      int   t0, t1;
      rst_n = 1'b0; clr_in = 1'b0; rd_in = 1'b0; clr_out = 1'b0; wr_out = 1'b0;
      lo = '0; ro = '0; adcdat = 1'b0; bclk_drv = 1'b1; lrck_drv = 1'b0;

      // Reset state
      xck_seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         xck_seen = xck_seen | xck;
      end
      check("rst_avail", avail, 0);
      check("rst_allowed", allowed, 1);
      check("rst_dacdat", dacdat, 0);
      check("rst_xck_static", xck_seen, 0);
      check("rst_left_in", li, 0);
      check("rst_right_in", ri, 0);
      rst_n = 1'b1;

      // XCK period
      t0 = -1; t1 = -1; prevx = xck;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (xck && !prevx) begin
            if (t0 < 0) t0 = c;
            else if (t1 < 0) t1 = c;
         end
         prevx = xck;
      end
      check("xck_period", t1 - t0, 4);

      // ADC capture and DAC playback, BCLK = CLOCK_50/16
      send_half(1'b1, 32'h12345678, 32, dac);
      check("dac_empty_h1", dac, 32'h0);
      send_half(1'b0, 32'h9ABCDEF0, 32, dac);
      check("dac_empty_h2", dac, 32'h0);
      check("avail_left_only", avail, 0);
      wr_pair(32'hA5A5A5A5, 32'h0F0F0F0F);
      send_half(1'b1, 32'h0BADF00D, 32, dac);
      check("dac_left", dac, 32'hA5A5A5A5);
      check("avail_frame1", avail, 1);
      check("left_in_1", li, 32'h12345678);
      check("right_in_1", ri, 32'h9ABCDEF0);
      rd_pulse();
      check("avail_after_read", avail, 0);
      send_half(1'b0, 32'h13579BDF, 32, dac);
      check("dac_right", dac, 32'h0F0F0F0F);
      send_half(1'b1, 32'h0000BEEF, 16, dac);
      check("dac_empty_short", dac, 32'h0);
      check("left_in_2", li, 32'h0BADF00D);
      check("right_in_2", ri, 32'h13579BDF);
      rd_pulse();
      send_half(1'b0, 32'h2468ACE0, 32, dac);
      check("dac_empty_32", dac, 32'h0);

      // Output FIFO full
      for (int i = 0; i < 128; i++) begin
         if (i == 127) check("allowed_at_127", allowed, 1);
         wr_pair(32'hC0000000 | i, 32'h30000000 | i);
      end
      check("allowed_full", allowed, 0);
      wr_pair(32'hDEADBEEF, 32'hDEADBEEF);
      check("allowed_after_129", allowed, 0);
      send_half(1'b1, 32'h11223344, 32, dac);
      check("dac_full_left", dac, 32'hC0000000);
      check("allowed_half_frame", allowed, 0);
      check("left_in_short", li, 32'hBEEF0000);
      check("right_in_3", ri, 32'h2468ACE0);
      rd_pulse();
      send_half(1'b0, 32'h55667788, 32, dac);
      check("dac_full_right", dac, 32'h30000000);
      check("allowed_after_frame", allowed, 1);

      // Clear of the input FIFOs
      send_half(1'b1, 32'h0, 0, dac);
      check("avail_pre_clear", avail, 1);
      check("left_in_4", li, 32'h11223344);
      check("right_in_4", ri, 32'h55667788);
      hp = 2;
      send_half(1'b0, 32'h50000000, 32, dac);
      @(negedge clk);
      clr_in = 1'b1;
      @(negedge clk);
      clr_in = 1'b0;
      check("avail_after_clear", avail, 0);

      // Input overflow: 130 frames, the oldest 128 are kept
      for (int k = 0; k < 130; k++) begin
         send_half(1'b1, 32'hA0000000 | k, 32, dac);
         send_half(1'b0, 32'h50000000 | (k + 1), 32, dac);
      end
      for (int k = 0; k < 128; k++) begin
         check("ovf_left", li, 32'hA0000000 | k);
         check("ovf_right", ri, 32'h50000000 | k);
         rd_pulse();
      end
      check("ovf_drained", avail, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
